cam_cfg_seq: RTL and testbench

- Parametrised camera configuration sequencer. It walks an external 1-cycle-latency configuration ROM entry by entry and issues register writes to the SCCB/I2C master over a valid/ready + done handshake.
- ROM entries carry three meanings: register write, programmable delay, or end-of-table.
- Adds behaviour the plain ROM lacks: programmable delays, NACK retry with an error exit, restart on demand, and progress/status reporting.
- Sits between the config ROM and the SCCB master inside the camera interface.

---
 rtl/cam_cfg_seq_if.sv | 26 ++
 rtl/cam_cfg_seq.sv | 186 ++++++++++++++++++
 tb/tb_cam_cfg_seq.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_cfg_seq_if.sv
// Register-write handshake between the camera config sequencer and the SCCB/I2C master.
//   wr_valid/wr_reg/wr_val : write request, held stable until accepted (valid & ready)
//   wr_ready               : master accepts the request
//   wr_done                : one-cycle pulse, transaction finished
//   wr_nack                : qualified by wr_done, slave NACKed the write
interface cam_cfg_seq_if #(
    parameter int unsigned REG_W = 8,
    parameter int unsigned VAL_W = 8
);
    logic             wr_valid;
    logic [REG_W-1:0] wr_reg;
    logic [VAL_W-1:0] wr_val;
    logic             wr_ready;
    logic             wr_done;
    logic             wr_nack;

    modport master (
        output wr_valid, wr_reg, wr_val,
        input  wr_ready, wr_done, wr_nack
    );

    modport slave (
        input  wr_valid, wr_reg, wr_val,
        output wr_ready, wr_done, wr_nack
    );
endinterface

// File: rtl/cam_cfg_seq.sv
// Camera configuration sequencer: walks a 1-cycle-latency config ROM and turns each
// entry into an SCCB register write, a programmable delay, or the end of the table.
// NACKed writes are re-issued up to MAX_RETRY times before stopping with an error.
//   i_clk, i_rstn      : clock, synchronous active-low reset
//   i_start            : pulse, (re)starts the walk from index 0 when not busy
//   o_rom_addr         : ROM index; i_rom_data {reg, val} is valid one cycle later
//   wr                 : write handshake to the SCCB master (master side)
//   o_busy/o_done/o_err: sequence status; done/err held until next start or reset
//   o_index            : entry currently processed (frozen on error)
module cam_cfg_seq #(
    parameter int unsigned      ADDR_W     = 7,
    parameter int unsigned      DEPTH      = 128,
    parameter int unsigned      REG_W      = 8,
    parameter int unsigned      VAL_W      = 8,
    parameter int unsigned      DELAY_UNIT = 25000,
    parameter int unsigned      MAX_RETRY  = 3,
    parameter logic [REG_W-1:0] MARK_REG   = REG_W'(8'hFF)
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_start,
    output logic [ADDR_W-1:0]      o_rom_addr,
    input  logic [REG_W+VAL_W-1:0] i_rom_data,
    cam_cfg_seq_if.master          wr,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err,
    output logic [ADDR_W-1:0]      o_index
);
    // val * DELAY_UNIT always fits without overflow
    localparam int unsigned CNT_W = VAL_W + $clog2(DELAY_UNIT);
    localparam int unsigned RTY_W = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, ISSUE, RESP, WAIT, ADVANCE, DONE, ERR
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  index_q, index_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               wr_valid_q, wr_valid_d;
    logic [REG_W-1:0]   wr_reg_q, wr_reg_d;
    logic [VAL_W-1:0]   wr_val_q, wr_val_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RTY_W-1:0]   retry_q, retry_d;

    logic [REG_W-1:0]   rom_reg;
    logic [VAL_W-1:0]   rom_val;
    logic               is_mark;

    // Entry decode: marker register selects delay (any val) or end (val all ones)
    assign rom_reg = i_rom_data[REG_W+VAL_W-1 -: REG_W];
    assign rom_val = i_rom_data[VAL_W-1:0];
    assign is_mark = (rom_reg == MARK_REG);

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q    <= IDLE;
            index_q    <= '0;
            rom_addr_q <= '0;
            wr_valid_q <= 1'b0;
            wr_reg_q   <= '0;
            wr_val_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            retry_q    <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            rom_addr_q <= rom_addr_d;
            wr_valid_q <= wr_valid_d;
            wr_reg_q   <= wr_reg_d;
            wr_val_q   <= wr_val_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        rom_addr_d = rom_addr_q;
        wr_valid_d = wr_valid_q;
        wr_reg_d   = wr_reg_q;
        wr_val_d   = wr_val_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        retry_d    = retry_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (i_start) begin
                    state_d    = FETCH;
                    index_d    = '0;
                    rom_addr_d = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                end
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                if (is_mark && (&rom_val)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (is_mark) begin
                    // zero-length delay skips WAIT entirely
                    if (rom_val == '0) begin
                        state_d = ADVANCE;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(CNT_W'(rom_val) * CNT_W'(DELAY_UNIT) - CNT_W'(1));
                    end
                end else begin
                    state_d    = ISSUE;
                    wr_reg_d   = rom_reg;
                    wr_val_d   = rom_val;
                    wr_valid_d = 1'b1;
                    retry_d    = '0;
                end
            end
            ISSUE: begin
                if (wr.wr_ready) begin
                    state_d    = RESP;
                    wr_valid_d = 1'b0;
                end
            end
            RESP: begin
                if (wr.wr_done) begin
                    if (!wr.wr_nack) begin
                        state_d = ADVANCE;
                    end else if (retry_q < RTY_W'(MAX_RETRY)) begin
                        state_d    = ISSUE;
                        wr_valid_d = 1'b1;
                        retry_d    = retry_q + RTY_W'(1);
                    end else begin
                        state_d = ERR;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ADVANCE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ADVANCE: begin
                if (index_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d    = FETCH;
                    index_d    = index_q + ADDR_W'(1);
                    rom_addr_d = index_q + ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_rom_addr  = rom_addr_q;
    assign wr.wr_valid = wr_valid_q;
    assign wr.wr_reg   = wr_reg_q;
    assign wr.wr_val   = wr_val_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_index     = index_q;
endmodule

// File: tb/tb_cam_cfg_seq.sv
// Self-checking bench for cam_cfg_seq: ROM model, reactive SCCB master model with
// stall/NACK injection, and a scoreboard of expected register writes.
module tb_cam_cfg_seq;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned REG_W  = 8;
    localparam int unsigned VAL_W  = 8;
    localparam int unsigned DU     = 10;
    localparam int unsigned MAXR   = 3;

    logic              clk   = 1'b0;
    logic              rstn  = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic              busy, done, err;
    logic [ADDR_W-1:0] index;

    always #5 clk = ~clk;

    cam_cfg_seq_if #(.REG_W(REG_W), .VAL_W(VAL_W)) wr_if ();

    cam_cfg_seq #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .REG_W(REG_W), .VAL_W(VAL_W),
        .DELAY_UNIT(DU), .MAX_RETRY(MAXR), .MARK_REG(8'hFF)
    ) dut (
        .i_clk(clk), .i_rstn(rstn), .i_start(start),
        .o_rom_addr(rom_addr), .i_rom_data(rom_data), .wr(wr_if),
        .o_busy(busy), .o_done(done), .o_err(err), .o_index(index)
    );

    logic [15:0] rom [0:(1<<ADDR_W)-1];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q[$];
    bit          nack_q[$];
    int          stall_left = 0;
    int          n_wr = 0;
    int          done_cnt = 0;
    bit          pend_nack = 1'b0;
    int          first_valid = -1;
    int          start_cyc = 0;
    int          n0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // SCCB master model: decisions made on the falling edge for the next rising edge
    initial begin
        wr_if.wr_ready = 1'b1;
        wr_if.wr_done  = 1'b0;
        wr_if.wr_nack  = 1'b0;
        forever begin
            @(negedge clk);
            wr_if.wr_done = 1'b0;
            wr_if.wr_nack = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    wr_if.wr_done = 1'b1;
                    wr_if.wr_nack = pend_nack;
                end
            end
            if (wr_if.wr_valid && first_valid < 0) first_valid = cyc;
            if (wr_if.wr_valid && stall_left > 0) begin
                wr_if.wr_ready = 1'b0;
                stall_left--;
                if (exp_q.size() > 0)
                    check("stall_hold", {wr_if.wr_valid, wr_if.wr_reg, wr_if.wr_val},
                          {1'b1, exp_q[0]});
            end else begin
                wr_if.wr_ready = 1'b1;
            end
            if (wr_if.wr_valid && wr_if.wr_ready) begin
                n_wr++;
                if (exp_q.size() == 0) check("extra_write", 32'd1, 32'd0);
                else check("write", {wr_if.wr_reg, wr_if.wr_val}, exp_q.pop_front());
                pend_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
                done_cnt  = 2;
            end
        end
    end

    task automatic clear_rom;
        for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 16'hFFFF;
    endtask

    task automatic pulse_start;
        first_valid = -1;
        start_cyc   = cyc;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int k = 0;
        while (!(done || err) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!(done || err)) check(tag, 32'd0, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clear_rom();
        repeat (3) @(negedge clk);
        check("rst_status", {busy, done, err, wr_if.wr_valid}, 4'b0000);
        check("rst_index", {index, rom_addr}, 0);
        check("rst_wr", {wr_if.wr_reg, wr_if.wr_val}, 0);
        rstn = 1'b1;
        @(negedge clk);

        // two writes then end marker
        rom[0] = 16'h1280; rom[1] = 16'h1100; rom[2] = 16'hFFFF;
        exp_q.push_back(16'h1280); exp_q.push_back(16'h1100);
        n0 = n_wr;
        pulse_start();
        check("t1_busy", busy, 1);
        wait_end("t1_timeout");
        check("t1_latency", 32'(first_valid - start_cyc), 3);
        check("t1_nwr", 32'(n_wr - n0), 2);
        check("t1_status", {busy, done, err}, 3'b010);
        check("t1_index", index, 2);

        // 2-unit delay, zero delay, then a write
        clear_rom();
        rom[0] = 16'hFF02; rom[1] = 16'hFF00; rom[2] = 16'h3A04;
        exp_q.push_back(16'h3A04);
        pulse_start();
        wait_end("t2_timeout");
        check("t2_latency", 32'(first_valid - start_cyc), 3 + (3 + 2 * DU) + 3);
        check("t2_status", {busy, done, err}, 3'b010);

        // ready held low 7 cycles
        clear_rom();
        rom[0] = 16'h0C00;
        exp_q.push_back(16'h0C00);
        n0 = n_wr;
        stall_left = 7;
        pulse_start();
        wait_end("t3_timeout");
        check("t3_nwr", 32'(n_wr - n0), 1);
        check("t3_stall_used", 32'(stall_left), 0);

        // three NACKs then ACK: sequence continues
        clear_rom();
        rom[0] = 16'h1418; rom[1] = 16'h1234;
        repeat (4) exp_q.push_back(16'h1418);
        exp_q.push_back(16'h1234);
        nack_q = '{1, 1, 1, 0};
        n0 = n_wr;
        pulse_start();
        wait_end("t4_timeout");
        check("t4_nwr", 32'(n_wr - n0), 5);
        check("t4_status", {busy, done, err}, 3'b010);

        // four NACKs: error at index 1, nothing further written
        clear_rom();
        rom[0] = 16'h0101; rom[1] = 16'h1418; rom[2] = 16'h5678;
        exp_q.push_back(16'h0101);
        repeat (4) exp_q.push_back(16'h1418);
        nack_q = '{0, 1, 1, 1, 1};
        n0 = n_wr;
        pulse_start();
        wait_end("t5_timeout");
        repeat (20) @(negedge clk);
        check("t5_nwr", 32'(n_wr - n0), 5);
        check("t5_status", {busy, done, err}, 3'b001);
        check("t5_index", index, 1);

        // no end marker: DEPTH limits the walk; restart from ERR; start while busy ignored
        clear_rom();
        for (int i = 0; i < 4; i++) begin
            rom[i] = 16'h2001 + 16'(i * 16'h0101);
            exp_q.push_back(16'h2001 + 16'(i * 16'h0101));
        end
        n0 = n_wr;
        pulse_start();
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end("t6_timeout");
        check("t6_nwr", 32'(n_wr - n0), 4);
        check("t6_status", {busy, done, err}, 3'b010);
        check("t6_index", index, DEPTH - 1);

        // start from DONE restarts at index 0
        clear_rom();
        rom[0] = 16'h3311;
        exp_q.push_back(16'h3311);
        pulse_start();
        check("t7_index0", index, 0);
        wait_end("t7_timeout");
        check("t7_status", {busy, done, err, index}, {3'b010, 7'd1});

        // reset while a write is pending
        clear_rom();
        rom[0] = 16'h4455;
        exp_q.push_back(16'h4455);
        stall_left = 20;
        n0 = n_wr;
        pulse_start();
        begin
            int k = 0;
            while (!wr_if.wr_valid && k < 20) begin
                @(negedge clk);
                k++;
            end
        end
        check("t8_valid_seen", wr_if.wr_valid, 1);
        rstn = 1'b0;
        @(negedge clk);
        check("t8_rst_status", {busy, done, err, wr_if.wr_valid}, 4'b0000);
        check("t8_rst_bus", {index, rom_addr, wr_if.wr_reg, wr_if.wr_val}, 0);
        rstn = 1'b1;
        exp_q.delete();
        stall_left = 0;
        repeat (10) @(negedge clk);
        check("t8_nwr", 32'(n_wr - n0), 0);
        check("t8_idle", {busy, done, err}, 3'b000);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
